// File: rtl/updown_count_sequencer.sv
// updown_count_sequencer: command-driven controller around an up/down counter.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready handshake with
//        cmd_op (00 LOAD, 01 UP, 10 DOWN, 11 CLEAR) and cmd_arg; pause freezes
//        stepping; count is the registered value; busy/done/wrap are status.
module updown_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAX  = '1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] remaining;
   logic             dir_down;

   logic accept;
   logic is_step_op;
   logic step;

   assign accept     = cmd_valid && (state == IDLE);
   assign is_step_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
   assign step       = (state == RUN) && !pause;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = IDLE;
      unique case (state)
         IDLE: begin
            if (!accept) begin
               state_nxt = IDLE;
            end else if (is_step_op && (cmd_arg != ZERO)) begin
               state_nxt = RUN;
            end else begin
               state_nxt = DONE;
            end
         end
         RUN: begin
            if (pause) begin
               state_nxt = PAUSE;
            end else if (remaining == ONE) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RUN;
            end
         end
         PAUSE: state_nxt = pause ? PAUSE : RUN;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cmd_ready = (state == IDLE);
      busy      = (state != IDLE);
      done      = (state == DONE);
   end

   // Datapath: count, remaining steps, latched direction and wrap pulse.
   // wrap defaults low every edge so it is a single-cycle pulse aligned
   // with the wrapped count value.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         remaining <= '0;
         dir_down  <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (accept) begin
            unique case (cmd_op)
               OP_LOAD:  count <= cmd_arg;
               OP_CLEAR: count <= '0;
               OP_UP, OP_DOWN: begin
                  if (cmd_arg != ZERO) begin
                     dir_down  <= (cmd_op == OP_DOWN);
                     remaining <= cmd_arg;
                  end
               end
               default: count <= count;
            endcase
         end
         if (step) begin
            remaining <= remaining - ONE;
            if (dir_down) begin
               count <= count - ONE;
               wrap  <= (count == ZERO);
            end else begin
               count <= count + ONE;
               wrap  <= (count == MAX);
            end
         end
      end
   end

endmodule

// File: tb/tb_updown_count_sequencer.sv
// tb_updown_count_sequencer: directed plus randomized self-checking bench.
// Expectations come from transaction-level arithmetic on each command.
module tb_updown_count_sequencer;

   localparam logic [1:0] OP_LD = 2'd0;
   localparam logic [1:0] OP_UP = 2'd1;
   localparam logic [1:0] OP_DN = 2'd2;
   localparam logic [1:0] OP_CL = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_arg;
   logic       pause;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       wrap;

   int checks = 0;
   int errors = 0;
   logic [3:0] m_count;

   always #5 clk = ~clk;

   updown_count_sequencer #(.WIDTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_arg(cmd_arg),
      .pause(pause),
      .count(count),
      .busy(busy),
      .done(done),
      .wrap(wrap)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one command from IDLE and follow it to completion.
   // pa: pause after this many observed steps (-1 = none); pl: pause length.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg,
                          input int pa, input int pl);
      logic [3:0] prev;
      logic [3:0] nxt;
      logic [3:0] exp_final;
      int exp_lat, exp_wraps, wraps, steps, prem, lat;
      bit stepping, trig, up;
      up = (op == OP_UP);
      stepping = ((op == OP_UP) || (op == OP_DN)) && (arg != 4'd0);
      case (op)
         OP_LD:   exp_final = arg;
         OP_CL:   exp_final = 4'd0;
         OP_UP:   exp_final = 4'(m_count + arg);
         default: exp_final = 4'(m_count - arg);
      endcase
      exp_lat = stepping ? int'(arg) + 1 : 1;
      if (stepping && pa >= 0 && pa < int'(arg)) exp_lat += pl + 1;
      if (up) exp_wraps = (int'(m_count) + int'(arg)) / 16;
      else if (int'(arg) > int'(m_count))
         exp_wraps = (int'(arg) - int'(m_count) - 1) / 16 + 1;
      else exp_wraps = 0;
      check("ready_before_cmd", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_arg = arg;
      tick();
      cmd_valid = 1'b0;
      prev = m_count;
      steps = 0; wraps = 0; lat = 0; trig = 0; prem = 0;
      for (int c = 1; c <= 200; c++) begin
         check("busy_active", busy, 1);
         if (stepping && c == 1) check("no_step_at_accept", count, m_count);
         if (stepping && count !== prev) begin
            nxt = up ? 4'(prev + 4'd1) : 4'(prev - 4'd1);
            check("step_value", count, nxt);
            check("wrap_on_step", wrap, up ? (prev == 4'hF) : (prev == 4'h0));
            if (wrap === 1'b1) wraps++;
            steps++;
            prev = count;
         end else if (stepping) begin
            check("wrap_idle_cycle", wrap, 0);
         end
         if (done === 1'b1) begin
            lat = c;
            break;
         end
         if (prem > 0) begin
            prem--;
            if (prem == 0) pause = 1'b0;
         end else if (!trig && stepping && pa >= 0 && pa < int'(arg)
                      && steps == pa) begin
            trig = 1;
            pause = 1'b1;
            prem = pl;
         end
         tick();
      end
      pause = 1'b0;
      check("done_latency", lat, exp_lat);
      check("final_count", count, exp_final);
      if (stepping) check("wrap_total", wraps, exp_wraps);
      else check("wrap_nostep", wrap, 0);
      m_count = exp_final;
      tick();
      check("done_single", done, 0);
      check("ready_after", cmd_ready, 1);
      check("busy_after", busy, 0);
      check("wrap_after", wrap, 0);
      check("count_hold", count, m_count);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = OP_LD;
      cmd_arg = 4'd0;
      pause = 1'b0;
      m_count = 4'd0;

      // Reset
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_count", count, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wrap", wrap, 0);

      // LOAD back-to-back
      run_cmd(OP_LD, 4'd9, -1, 0);
      run_cmd(OP_LD, 4'd3, -1, 0);

      // UP across the top
      run_cmd(OP_LD, 4'd14, -1, 0);
      run_cmd(OP_UP, 4'd3, -1, 0);
      check("up3_result", count, 1);

      // DOWN across zero with a pause episode
      run_cmd(OP_LD, 4'd2, -1, 0);
      run_cmd(OP_DN, 4'd4, 2, 3);
      check("dn4_result", count, 14);

      // Zero step and CLEAR
      run_cmd(OP_UP, 4'd0, -1, 0);
      run_cmd(OP_LD, 4'd7, -1, 0);
      run_cmd(OP_CL, 4'd0, -1, 0);

      // Reset mid-run after the third step
      run_cmd(OP_LD, 4'd14, -1, 0);
      cmd_valid = 1'b1;
      cmd_op = OP_UP;
      cmd_arg = 4'd10;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      check("mid_third_step", count, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_count", count, 0);
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_done", done, 0);
      check("mid_rst_wrap", wrap, 0);
      tick();
      check("mid_rst_nodone", done, 0);
      check("mid_rst_idle", busy, 0);
      m_count = 4'd0;

      // cmd_valid held while busy is accepted only once ready returns
      cmd_valid = 1'b1;
      cmd_op = OP_UP;
      cmd_arg = 4'd2;
      tick();
      cmd_op = OP_LD;
      cmd_arg = 4'd5;
      check("hold_c1", count, 0);
      tick();
      check("hold_c2", count, 1);
      tick();
      check("hold_c3", count, 2);
      check("hold_done_up", done, 1);
      tick();
      check("hold_ready", cmd_ready, 1);
      check("hold_not_taken", count, 2);
      tick();
      cmd_valid = 1'b0;
      check("hold_loaded", count, 5);
      check("hold_done_ld", done, 1);
      tick();
      check("hold_once_done", done, 0);
      check("hold_once_count", count, 5);
      check("hold_once_ready", cmd_ready, 1);
      m_count = 4'd5;

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         logic [1:0] op;
         logic [3:0] arg;
         int pa, pl;
         op = 2'($urandom_range(0, 3));
         arg = 4'($urandom_range(0, 15));
         pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
         pl = int'($urandom_range(1, 4));
         run_cmd(op, arg, pa, pl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_count_sequencer.md
Name: updown_count_sequencer

Overview:
Command-driven controller wrapped around a WIDTH-bit up/down counter datapath.
- Accepts LOAD, CLEAR, UP-by-N and DOWN-by-N commands over a valid/ready handshake.
- Steps the counter one count per cycle, with a pause input.
- Signals completion with a one-cycle done pulse.
- Sits between a host FSM or register interface and any logic consuming the count value.

Parameters:
WIDTH, 4, width of count, cmd_arg and internal step-remaining register

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command; combinational, equals (state==IDLE)
cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
cmd_arg  input  WIDTH  LOAD: new count value; UP/DOWN: step count N; CLEAR: ignored
pause  input  1  freezes stepping while high (RUN/PAUSE only)
count  output  WIDTH  registered counter value
busy  output  1  state != IDLE
done  output  1  high exactly one cycle per accepted command (state==DONE)
wrap  output  1  registered one-cycle pulse; high in the cycle count shows a wrapped value

Behaviour:
- Reset: synchronous, active-high, wins over everything and is allowed at any point. Sets state=IDLE, count=0, remaining=0, wrap=0, so done=0, busy=0, cmd_ready=1.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding; unused code -> IDLE).
- Accept: a command is accepted only when cmd_valid && cmd_ready at a rising edge. cmd_valid while not ready is ignored; the host holds it.
- IDLE, on accept:
  - LOAD: count<=cmd_arg; ->DONE.
  - CLEAR: count<=0; ->DONE.
  - UP/DOWN with cmd_arg==0: count unchanged; ->DONE.
  - UP/DOWN with cmd_arg=N>0: latch direction, remaining<=N; ->RUN. No step at the accept edge.
- IDLE, no accept: stay; count holds; pause ignored.
- RUN, pause=0: step at this edge.
  - count <= count±1, modulo 2^WIDTH.
  - remaining <= remaining-1.
  - If remaining==1 -> DONE, else stay RUN.
- RUN, pause=1: no step; ->PAUSE.
- PAUSE: no step. pause=1 stays; pause=0 -> RUN. Stepping resumes on the edge after RUN is re-entered, so resuming costs one cycle.
- DONE: done=1 for this cycle; unconditionally ->IDLE. No command is accepted in DONE.
- Wrap rule:
  - wrap<=1 at a step edge where UP goes from 2^WIDTH-1 to 0, or DOWN goes from 0 to 2^WIDTH-1.
  - Otherwise wrap<=0.
  - LOAD/CLEAR never set wrap.
- Latency, accept at edge k:
  - LOAD/CLEAR/zero-step: done high in cycle k+1; cmd_ready high in cycle k+2.
  - UP/DOWN N, no pause: steps at edges k+1..k+N; done in cycle k+N+1; ready in cycle k+N+2. Each pause episode adds (pause-high cycles + 1).
- Arithmetic: unsigned, wrap-around, no saturation. Final count = start ± N mod 2^WIDTH.
- Reset mid-operation: the command is abandoned, with no done pulse and no wrap pulse.

Test Plan:
1. Reset: rst high 2 cycles, then low -> count=0, cmd_ready=1, busy=0, done=0, wrap=0.
2. LOAD 9 -> count=9 the cycle after accept; done high exactly 1 cycle; cmd_ready returns 2 cycles after accept. Then LOAD 3 accepted at the first ready cycle -> count=3.
3. LOAD 14, then UP 3, no pause -> count sequence 15,0,1. wrap high only in the cycle count=0. done once, in the cycle after count=1. busy high for 4 cycles.
4. LOAD 2, then DOWN 4, with pause high for 3 cycles after the second step:
   - count sequence 1,0, held at 0 for 4 cycles (3 pause + 1 resume), then 15,14.
   - wrap pulse with 15; final count=14; done once.
5. UP 0 -> count unchanged, done next cycle, no wrap. CLEAR from count=7 -> count=0, done next cycle.
6. UP 10, then rst pulsed after the 3rd step -> count=0 the next cycle, state IDLE, no done. cmd_valid held high during RUN is not accepted until cmd_ready, then is accepted once.
